pll_reset_sequencer: RTL and testbench

Sequences the iCE40 PLL (SB_PLL40_PAD wrapper) after power-up and after loss of lock. Runs on the always-present 12 MHz board clock and drives the PLL's RESETB. It synchronises the PLL lock output, requires lock to be stable before releasing the system reset, and retries the PLL on lock timeout. Sits at the top level between the board clock pin, the PLL wrapper and the core reset tree. A core-domain reset synchroniser downstream is out of scope.

---
 rtl/pll_ctrl_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 115 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the PLL reset sequencer and its helpers.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_seq_state_t;

  localparam int DEF_PLL_RESET_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 12000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1200;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int LOCK_LOSS_COUNT_W       = 8;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous input pins.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings the PLL out of reset, waits for a stable lock, retries on timeout
// and holds the core in reset whenever the PLL is not trustworthy.
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  locked_async,
  output logic                                  pll_resetb,
  output logic                                  system_reset,
  output logic                                  ready,
  output logic                                  fault,
  output logic [clog2_min1(MAX_RETRIES+1)-1:0]  retry_count,
  output logic [LOCK_LOSS_COUNT_W-1:0]          lock_loss_count,
  output logic [2:0]                            state
);

  localparam int CNT_W = clog2_min1(max3(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES));
  localparam int RC_W  = clog2_min1(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX    = RC_W'(MAX_RETRIES);

  pll_seq_state_t   cur_state;
  pll_seq_state_t   next_state;
  logic [CNT_W-1:0] cycle_cnt;
  logic             lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked_async),
    .q     (lock_s)
  );

  always_ff @(posedge clock) begin
    if (reset) cur_state <= PLL_RESET;
    else       cur_state <= next_state;
  end

  // A lock seen in the timeout cycle takes priority over retrying the PLL.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      PLL_RESET: if (cycle_cnt == RESET_LAST) next_state = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)                          next_state = STABILIZE;
        else if (cycle_cnt == TIMEOUT_LAST)  next_state = (retry_count == RETRY_MAX) ? FAULT : PLL_RESET;
      end
      STABILIZE: begin
        if (!lock_s)                         next_state = WAIT_LOCK;
        else if (cycle_cnt == STABLE_LAST)   next_state = RUN;
      end
      RUN:       if (!lock_s) next_state = WAIT_LOCK;
      FAULT:     next_state = FAULT;
      default:   next_state = PLL_RESET;
    endcase
  end

  always_comb begin
    pll_resetb   = 1'b1;
    system_reset = 1'b1;
    fault        = 1'b0;
    case (cur_state)
      PLL_RESET: pll_resetb = 1'b0;
      RUN:       system_reset = 1'b0;
      FAULT: begin
        pll_resetb = 1'b0;
        fault      = 1'b1;
      end
      default: ;
    endcase
  end

  assign ready = ~system_reset;
  assign state = cur_state;

  // Phase timer restarts on every transition; it idles in RUN and FAULT.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (next_state != cur_state || cur_state == RUN || cur_state == FAULT) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retry_count <= '0;
    end else if (cur_state == WAIT_LOCK && next_state == PLL_RESET) begin
      retry_count <= retry_count + 1'b1;
    end else if (cur_state != RUN && next_state == RUN) begin
      retry_count <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_loss_count <= '0;
    end else if (cur_state == RUN && next_state == WAIT_LOCK && lock_loss_count != '1) begin
      lock_loss_count <= lock_loss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: a phase/age reference model predicts every cycle's outputs
// and a monitor compares them against the sequencer just after each edge.
module tb_pll_reset_sequencer;

  localparam int P_CYC = 4;
  localparam int T_CYC = 20;
  localparam int S_CYC = 8;
  localparam int MAX_R = 2;

  logic       clock;
  logic       reset;
  logic       locked_async;
  logic       pll_resetb;
  logic       system_reset;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       resetb;
    logic       sysrst;
    logic       rdy;
    logic       flt;
    logic [1:0] rc;
    logic [7:0] llc;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: phase 0..4, age = cycles spent in the current phase.
  int   m_phase, m_age, m_retries, m_losses;
  bit   m_pipe[$];

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES    (P_CYC),
    .LOCK_TIMEOUT_CYCLES (T_CYC),
    .LOCK_STABLE_CYCLES  (S_CYC),
    .MAX_RETRIES         (MAX_R)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .locked_async    (locked_async),
    .pll_resetb      (pll_resetb),
    .system_reset    (system_reset),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_phase   = 0;
    m_age     = 0;
    m_retries = 0;
    m_losses  = 0;
    m_pipe    = {1'b0, 1'b0};
  endtask

  task automatic model_edge(input bit rst, input bit lk);
    bit l;
    int nxt;
    if (rst) begin
      model_reset();
      return;
    end
    l = m_pipe.pop_front();
    m_pipe.push_back(lk);
    nxt = m_phase;
    case (m_phase)
      0: if (m_age == P_CYC - 1) nxt = 1;
      1: begin
        if (l) nxt = 2;
        else if (m_age == T_CYC - 1) begin
          if (m_retries == MAX_R) nxt = 4;
          else begin
            m_retries++;
            nxt = 0;
          end
        end
      end
      2: begin
        if (!l) nxt = 1;
        else if (m_age == S_CYC - 1) begin
          nxt = 3;
          m_retries = 0;
        end
      end
      3: if (!l) begin
        nxt = 1;
        if (m_losses < 255) m_losses++;
      end
      default: ;
    endcase
    m_age   = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  function automatic out_t model_outputs();
    out_t o;
    o.st     = 3'(m_phase);
    o.resetb = !(m_phase == 0 || m_phase == 4);
    o.sysrst = (m_phase != 3);
    o.rdy    = (m_phase == 3);
    o.flt    = (m_phase == 4);
    o.rc     = 2'(m_retries);
    o.llc    = 8'(m_losses);
    return o;
  endfunction

  task automatic apply_stimulus(input bit rst, input bit lk);
    @(negedge clock);
    reset        = rst;
    locked_async = lk;
    model_edge(rst, lk);
    exp_q.push_back(model_outputs());
  endtask

  task automatic hold(input bit lk, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, lk);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0);
  endtask

  task automatic check_output(input out_t e);
    out_t a;
    a = '{state, pll_resetb, system_reset, ready, fault, retry_count, lock_loss_count};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL outputs cycle %0d: got st=%0d resetb=%0b sysrst=%0b rdy=%0b flt=%0b rc=%0d llc=%0d, want st=%0d resetb=%0b sysrst=%0b rdy=%0b flt=%0b rc=%0d llc=%0d",
               cycle, a.st, a.resetb, a.sysrst, a.rdy, a.flt, a.rc, a.llc,
               e.st, e.resetb, e.sysrst, e.rdy, e.flt, e.rc, e.llc);
    end
  endtask

  always @(posedge clock) begin
    #1;
    cycle++;
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  initial begin
    int seg_len;
    bit seg_lvl;
    reset        = 1'b1;
    locked_async = 1'b0;
    model_reset();

    $display("[TB] power-up with lock at cycle 10");
    do_reset(2);
    hold(1'b0, 10);
    hold(1'b1, 30);

    $display("[TB] lock never asserts");
    do_reset(1);
    hold(1'b0, 180);

    $display("[TB] lock drop mid-stabilize");
    do_reset(1);
    hold(1'b0, 10);
    hold(1'b1, 6);
    hold(1'b0, 3);
    hold(1'b1, 40);

    $display("[TB] lock loss in run");
    hold(1'b0, 5);
    hold(1'b1, 30);

    $display("[TB] repeated lock losses");
    for (int i = 0; i < 300; i++) begin
      hold(1'b0, 1);
      hold(1'b1, 12);
    end

    $display("[TB] reset in run and in fault");
    do_reset(1);
    hold(1'b1, 30);
    do_reset(1);
    hold(1'b0, 100);
    do_reset(1);
    hold(1'b0, 10);

    $display("[TB] random lock pattern");
    for (int s = 0; s < 150; s++) begin
      seg_len = $urandom_range(1, 30);
      seg_lvl = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < seg_len; i++)
        apply_stimulus(($urandom_range(0, 299) == 0), seg_lvl);
    end

    @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
